// File: rtl/cluster_soc_evt_buffer_pkg.sv
// ----------------------------------------------------------------------------
// pulp_cluster_package (SoC-event buffer slice)
// Register word offsets (cfg_add_i[3:2]) and field bit positions shared by the
// SoC-event buffer and anything that programs it.
// ----------------------------------------------------------------------------
package pulp_cluster_package;

  // Register word offsets, compared against cfg_add_i[3:2]
  localparam logic [1:0] SOCEVT_STATUS = 2'd0;
  localparam logic [1:0] SOCEVT_DROP   = 2'd1;
  localparam logic [1:0] SOCEVT_CTRL   = 2'd2;
  localparam logic [1:0] SOCEVT_LAST   = 2'd3;

  // CTRL bit indices
  localparam int unsigned SOCEVT_CTRL_EN    = 0;
  localparam int unsigned SOCEVT_CTRL_FLUSH = 1;

  // STATUS bit indices
  localparam int unsigned SOCEVT_STATUS_EMPTY = 0;
  localparam int unsigned SOCEVT_STATUS_FULL  = 1;
  localparam int unsigned SOCEVT_STATUS_OVF   = 2;
  localparam int unsigned SOCEVT_STATUS_CNT   = 8;

endpackage

// File: rtl/cluster_soc_evt_buffer_if.sv
// ----------------------------------------------------------------------------
// cluster_soc_evt_buffer_if
// Bundles the three channels of the SoC-event buffer:
//   soc_evt_*  : SoC event strobe in (never back-pressured)
//   evt_*      : valid/ready stream toward the event unit
//   cfg_*      : slave-peripheral register port (req/gnt + registered response)
// master modport = environment side, slave modport = the buffer itself.
// ----------------------------------------------------------------------------
interface cluster_soc_evt_buffer_if #(
  parameter int EVNT_WIDTH = 8,
  parameter int ID_WIDTH   = 5
) ();

  logic                  soc_evt_valid_i;
  logic [EVNT_WIDTH-1:0] soc_evt_data_i;
  logic                  soc_evt_ready_o;

  logic                  evt_valid_o;
  logic [EVNT_WIDTH-1:0] evt_data_o;
  logic                  evt_ready_i;

  logic                  cfg_req_i;
  logic [31:0]           cfg_add_i;
  logic                  cfg_wen_i;
  logic [31:0]           cfg_wdata_i;
  logic [3:0]            cfg_be_i;
  logic [ID_WIDTH-1:0]   cfg_id_i;
  logic                  cfg_gnt_o;
  logic                  cfg_r_valid_o;
  logic [31:0]           cfg_r_rdata_o;
  logic                  cfg_r_opc_o;
  logic [ID_WIDTH-1:0]   cfg_r_id_o;

  modport master (
    output soc_evt_valid_i, soc_evt_data_i, evt_ready_i,
           cfg_req_i, cfg_add_i, cfg_wen_i, cfg_wdata_i, cfg_be_i, cfg_id_i,
    input  soc_evt_ready_o, evt_valid_o, evt_data_o,
           cfg_gnt_o, cfg_r_valid_o, cfg_r_rdata_o, cfg_r_opc_o, cfg_r_id_o
  );

  modport slave (
    input  soc_evt_valid_i, soc_evt_data_i, evt_ready_i,
           cfg_req_i, cfg_add_i, cfg_wen_i, cfg_wdata_i, cfg_be_i, cfg_id_i,
    output soc_evt_ready_o, evt_valid_o, evt_data_o,
           cfg_gnt_o, cfg_r_valid_o, cfg_r_rdata_o, cfg_r_opc_o, cfg_r_id_o
  );

endinterface

// File: rtl/cluster_soc_evt_buffer_fifo.sv
// ----------------------------------------------------------------------------
// soc_evt_fifo
// Parametric synchronous FIFO with push/pop/flush.
//   clk_i, rst_ni : clock, async active-low reset (pointers/count only)
//   push_i        : write data_i (accepted when not full, or full with pop)
//   pop_i         : drop head entry (ignored when empty)
//   flush_i       : empty the FIFO; same-cycle push/pop are ignored
//   data_o        : head entry, forced to 0 while empty
//   empty_o, full_o, count_o : occupancy
// ----------------------------------------------------------------------------
module soc_evt_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [DATA_W-1:0]            data_i,
  output logic [DATA_W-1:0]            data_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;

  assign do_pop  = pop_i && !empty_o && !flush_i;
  // A full FIFO can still take a push when the head leaves in the same cycle
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; the empty gate below hides stale entries
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/cluster_soc_evt_buffer.sv
// ----------------------------------------------------------------------------
// cluster_soc_evt_buffer
// Buffers SoC peripheral event IDs in a FIFO and streams them to the event
// unit. Events arriving while full (without a same-cycle pop) are dropped and
// counted; events arriving while disabled are discarded silently.
//   clk_i  : cluster clock
//   rst_ni : async active-low reset
//   bus    : slave modport of cluster_soc_evt_buffer_if
//            soc_evt_* in, evt_* stream out, cfg_* register port
// Registers (cfg_add_i[3:2]): STATUS, DROP_CNT, CTRL, LAST_DROP.
// ----------------------------------------------------------------------------
module cluster_soc_evt_buffer
  import pulp_cluster_package::*;
#(
  parameter int EVNT_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int ID_WIDTH   = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  cluster_soc_evt_buffer_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic                  fifo_empty;
  logic                  fifo_full;
  logic [CNT_W-1:0]      fifo_count;
  logic [EVNT_WIDTH-1:0] fifo_data;

  logic                  en_q;
  logic                  ovf_q;
  logic [31:0]           drop_cnt_q;
  logic [EVNT_WIDTH-1:0] last_drop_q;

  logic [1:0]            cfg_off;
  logic                  cfg_unaligned;
  logic                  cfg_wr;
  logic                  ctrl_wr;
  logic                  drop_clr;
  logic                  flush;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic [31:0]           rdata_mux;

  logic                  vld_p1;
  logic [31:0]           rdata_p1;
  logic                  opc_p1;
  logic [ID_WIDTH-1:0]   id_p1;

  logic                  unused_cfg;
  assign unused_cfg = ^{bus.cfg_add_i[31:4], bus.cfg_wdata_i[31:2], bus.cfg_be_i[3:1]};

  // Address decode; unaligned accesses never write
  assign cfg_off       = bus.cfg_add_i[3:2];
  assign cfg_unaligned = |bus.cfg_add_i[1:0];
  assign cfg_wr        = bus.cfg_req_i && !bus.cfg_wen_i && !cfg_unaligned;
  assign ctrl_wr       = cfg_wr && (cfg_off == SOCEVT_CTRL) && bus.cfg_be_i[0];
  assign drop_clr      = cfg_wr && (cfg_off == SOCEVT_DROP) && (|bus.cfg_be_i);
  assign flush         = ctrl_wr && bus.cfg_wdata_i[SOCEVT_CTRL_FLUSH];

  // Flush overrides both sides of the FIFO and suppresses drop accounting
  assign pop  = !fifo_empty && bus.evt_ready_i && !flush;
  assign push = bus.soc_evt_valid_i && en_q && (!fifo_full || pop) && !flush;
  assign drop = bus.soc_evt_valid_i && en_q && fifo_full && !pop && !flush;

  soc_evt_fifo #(
    .DATA_W (EVNT_WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (bus.soc_evt_data_i),
    .data_o  (fifo_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign bus.soc_evt_ready_o = 1'b1;
  assign bus.evt_valid_o     = !fifo_empty;
  assign bus.evt_data_o      = fifo_data;
  assign bus.cfg_gnt_o       = bus.cfg_req_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q        <= 1'b1;
      ovf_q       <= 1'b0;
      drop_cnt_q  <= '0;
      last_drop_q <= '0;
    end else begin
      if (ctrl_wr) en_q <= bus.cfg_wdata_i[SOCEVT_CTRL_EN];
      // A clear racing a drop leaves exactly that one drop recorded
      if (drop_clr)  drop_cnt_q <= drop ? 32'd1 : 32'd0;
      else if (drop) drop_cnt_q <= sat_inc(drop_cnt_q);
      if (drop)          ovf_q <= 1'b1;
      else if (drop_clr) ovf_q <= 1'b0;
      if (drop) last_drop_q <= bus.soc_evt_data_i;
    end
  end

  always_comb begin
    rdata_mux = '0;
    case (cfg_off)
      SOCEVT_STATUS: begin
        rdata_mux[SOCEVT_STATUS_EMPTY]           = fifo_empty;
        rdata_mux[SOCEVT_STATUS_FULL]            = fifo_full;
        rdata_mux[SOCEVT_STATUS_OVF]             = ovf_q;
        rdata_mux[SOCEVT_STATUS_CNT +: CNT_W]    = fifo_count;
      end
      SOCEVT_DROP: rdata_mux = drop_cnt_q;
      SOCEVT_CTRL: rdata_mux[SOCEVT_CTRL_EN] = en_q;
      default:     rdata_mux[EVNT_WIDTH-1:0] = last_drop_q;
    endcase
  end

  // ---- stage p1: registered response, one cycle after grant ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
      opc_p1   <= 1'b0;
      id_p1    <= '0;
    end else begin
      vld_p1 <= bus.cfg_req_i;
      if (bus.cfg_req_i) begin
        id_p1    <= bus.cfg_id_i;
        opc_p1   <= cfg_unaligned;
        rdata_p1 <= (bus.cfg_wen_i && !cfg_unaligned) ? rdata_mux : 32'd0;
      end
    end
  end

  assign bus.cfg_r_valid_o = vld_p1;
  assign bus.cfg_r_rdata_o = rdata_p1;
  assign bus.cfg_r_opc_o   = opc_p1;
  assign bus.cfg_r_id_o    = id_p1;

endmodule

// File: tb/tb_cluster_soc_evt_buffer.sv
// ----------------------------------------------------------------------------
// tb_cluster_soc_evt_buffer
// Directed bench for cluster_soc_evt_buffer. Inputs change and outputs are
// sampled on the falling clock edge; the DUT acts on the rising edge.
// ----------------------------------------------------------------------------
module tb_cluster_soc_evt_buffer;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  logic [4:0] next_id = 5'd1;

  cluster_soc_evt_buffer_if #(.EVNT_WIDTH(8), .ID_WIDTH(5)) bus ();

  cluster_soc_evt_buffer #(
    .EVNT_WIDTH (8),
    .FIFO_DEPTH (8),
    .ID_WIDTH   (5)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One register access; called on a falling edge, returns on the falling
  // edge after the grant edge with the response sampled.
  task automatic cfg(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input logic [4:0] id,
                     output logic [31:0] rdata, output logic opc);
    bus.cfg_req_i   = 1'b1;
    bus.cfg_wen_i   = wen;
    bus.cfg_add_i   = addr;
    bus.cfg_wdata_i = wdata;
    bus.cfg_be_i    = be;
    bus.cfg_id_i    = id;
    #1;
    check("cfg_gnt", 32'(bus.cfg_gnt_o), 32'd1);
    @(negedge clk);
    bus.cfg_req_i = 1'b0;
    check("cfg_r_valid", 32'(bus.cfg_r_valid_o), 32'd1);
    check("cfg_r_id", 32'(bus.cfg_r_id_o), 32'(id));
    rdata = bus.cfg_r_rdata_o;
    opc   = bus.cfg_r_opc_o;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        o;
    cfg(1'b1, addr, 32'd0, 4'hF, next_id, d, o);
    next_id = next_id + 5'd1;
    check({tag, "_opc"}, 32'(o), 32'd0);
    check(tag, d, exp);
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] be);
    logic [31:0] d;
    logic        o;
    cfg(1'b0, addr, data, be, next_id, d, o);
    next_id = next_id + 5'd1;
    check({tag, "_opc"}, 32'(o), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic        o;
    logic [7:0]  drain_exp [8];

    rst_n               = 1'b0;
    bus.soc_evt_valid_i = 1'b0;
    bus.soc_evt_data_i  = 8'h00;
    bus.evt_ready_i     = 1'b0;
    bus.cfg_req_i       = 1'b1;  // request held through reset: must get no response
    bus.cfg_add_i       = 32'h0;
    bus.cfg_wen_i       = 1'b1;
    bus.cfg_wdata_i     = 32'h0;
    bus.cfg_be_i        = 4'hF;
    bus.cfg_id_i        = 5'h1F;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_evt_valid", 32'(bus.evt_valid_o), 32'd0);
    check("rst_evt_data", 32'(bus.evt_data_o), 32'd0);
    check("rst_soc_ready", 32'(bus.soc_evt_ready_o), 32'd1);
    check("rst_r_valid", 32'(bus.cfg_r_valid_o), 32'd0);
    check("rst_r_rdata", bus.cfg_r_rdata_o, 32'd0);
    check("rst_r_opc", 32'(bus.cfg_r_opc_o), 32'd0);
    check("rst_r_id", 32'(bus.cfg_r_id_o), 32'd0);
    bus.cfg_req_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_r_valid", 32'(bus.cfg_r_valid_o), 32'd0);

    // In-order streaming, one cycle push-to-output
    bus.evt_ready_i     = 1'b1;
    bus.soc_evt_valid_i = 1'b1;
    bus.soc_evt_data_i  = 8'h11;
    @(negedge clk);
    check("s1_valid", 32'(bus.evt_valid_o), 32'd1);
    check("s1_data", 32'(bus.evt_data_o), 32'h11);
    bus.soc_evt_data_i = 8'h22;
    @(negedge clk);
    check("s2_valid", 32'(bus.evt_valid_o), 32'd1);
    check("s2_data", 32'(bus.evt_data_o), 32'h22);
    bus.soc_evt_data_i = 8'h33;
    @(negedge clk);
    check("s3_valid", 32'(bus.evt_valid_o), 32'd1);
    check("s3_data", 32'(bus.evt_data_o), 32'h33);
    bus.soc_evt_valid_i = 1'b0;
    @(negedge clk);
    check("s_drained", 32'(bus.evt_valid_o), 32'd0);
    rd("status_empty", 32'h0, 32'h0000_0001);

    // Overflow: 10 pushes into depth 8 with the consumer stalled
    bus.evt_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.soc_evt_valid_i = 1'b1;
      bus.soc_evt_data_i  = 8'(8'h40 + i);
      @(negedge clk);
    end
    bus.soc_evt_valid_i = 1'b0;
    check("ovf_head", 32'(bus.evt_data_o), 32'h40);
    rd("status_full_ovf", 32'h0, 32'h0000_0806);
    rd("drop_cnt_2", 32'h1A10_0004, 32'd2);
    rd("last_drop_49", 32'hC, 32'h49);

    // Full with simultaneous push and pop: accepted, not a drop
    bus.soc_evt_valid_i = 1'b1;
    bus.soc_evt_data_i  = 8'h5A;
    bus.evt_ready_i     = 1'b1;
    @(negedge clk);
    bus.soc_evt_valid_i = 1'b0;
    bus.evt_ready_i     = 1'b0;
    check("pp_head", 32'(bus.evt_data_o), 32'h41);
    rd("pp_status", 32'h0, 32'h0000_0806);
    rd("pp_drop", 32'h4, 32'd2);
    drain_exp = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h5A};
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 32'(bus.evt_valid_o), 32'd1);
      check("drain_data", 32'(bus.evt_data_o), 32'(drain_exp[i]));
      bus.evt_ready_i = 1'b1;
      @(negedge clk);
    end
    bus.evt_ready_i = 1'b0;
    check("drain_empty", 32'(bus.evt_valid_o), 32'd0);
    rd("drain_status", 32'h0, 32'h0000_0005);

    // Flush with 5 queued and a concurrent push/pop that must be ignored
    for (int i = 0; i < 5; i++) begin
      bus.soc_evt_valid_i = 1'b1;
      bus.soc_evt_data_i  = 8'(8'h61 + i);
      @(negedge clk);
    end
    bus.soc_evt_valid_i = 1'b0;
    rd("pre_flush_status", 32'h0, 32'h0000_0504);
    bus.soc_evt_valid_i = 1'b1;
    bus.soc_evt_data_i  = 8'h77;
    bus.evt_ready_i     = 1'b1;
    wr("flush_wr", 32'h8, 32'h3, 4'hF);
    bus.soc_evt_valid_i = 1'b0;
    bus.evt_ready_i     = 1'b0;
    check("flush_valid", 32'(bus.evt_valid_o), 32'd0);
    check("flush_data", 32'(bus.evt_data_o), 32'd0);
    rd("ctrl_after_flush", 32'h8, 32'h1);
    rd("status_after_flush", 32'h0, 32'h0000_0005);

    // be=0 write is a no-op; then disable and push
    wr("ctrl_be0", 32'h8, 32'h0, 4'h0);
    rd("ctrl_be0_rb", 32'h8, 32'h1);
    wr("ctrl_dis", 32'h8, 32'h0, 4'h1);
    rd("ctrl_dis_rb", 32'h8, 32'h0);
    for (int i = 0; i < 4; i++) begin
      bus.soc_evt_valid_i = 1'b1;
      bus.soc_evt_data_i  = 8'(8'h81 + i);
      @(negedge clk);
    end
    bus.soc_evt_valid_i = 1'b0;
    check("dis_valid", 32'(bus.evt_valid_o), 32'd0);
    rd("dis_status", 32'h0, 32'h0000_0005);
    rd("dis_drop", 32'h4, 32'd2);
    wr("drop_clr", 32'h4, 32'hDEAD_BEEF, 4'hF);
    rd("drop_clr_rb", 32'h4, 32'd0);
    rd("drop_clr_status", 32'h0, 32'h0000_0001);
    wr("ctrl_en", 32'h8, 32'h1, 4'h1);

    // Unaligned accesses
    cfg(1'b1, 32'h2, 32'd0, 4'hF, 5'h1B, d, o);
    check("unal_rd_opc", 32'(o), 32'd1);
    check("unal_rd_rdata", d, 32'd0);
    @(negedge clk);
    check("unal_rd_one_cycle", 32'(bus.cfg_r_valid_o), 32'd0);
    cfg(1'b0, 32'h9, 32'd0, 4'hF, 5'h03, d, o);
    check("unal_wr_opc", 32'(o), 32'd1);
    rd("unal_wr_ctrl_kept", 32'h8, 32'h1);

    // DROP_CNT clear racing a drop
    for (int i = 0; i < 8; i++) begin
      bus.soc_evt_valid_i = 1'b1;
      bus.soc_evt_data_i  = 8'(8'h90 + i);
      @(negedge clk);
    end
    bus.soc_evt_valid_i = 1'b0;
    rd("refill_status", 32'h0, 32'h0000_0802);
    bus.soc_evt_valid_i = 1'b1;
    bus.soc_evt_data_i  = 8'hA5;
    wr("race_clr", 32'h1A10_0004, 32'h0, 4'h1);
    bus.soc_evt_valid_i = 1'b0;
    rd("race_drop", 32'h4, 32'd1);
    rd("race_status", 32'h0, 32'h0000_0806);
    rd("race_last", 32'hC, 32'hA5);

    // Asynchronous reset mid-operation
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.evt_valid_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd("midrst_status", 32'h0, 32'h0000_0001);
    rd("midrst_drop", 32'h4, 32'd0);
    rd("midrst_ctrl", 32'h8, 32'h1);
    rd("midrst_last", 32'hC, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
